// File: rtl/conv33_pkg.sv
// Shared constants and helpers for the conv33 engine (window builder and convolver).
package conv33_pkg;

  localparam int KSIZE          = 3;
  localparam int DATA_WIDTH_DEF = 8;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv33_linebuf.sv
// One image row of pixel storage: combinational read, synchronous write, same address.
module conv33_linebuf
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset: output gating hides stale rows.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv33_window.sv
// Raster stream to 3x3 sliding window for conv33; two line buffers plus a shift-register window.
// Optional stride-2 windowing when CONV33_WINDOW_STRIDE2_EN is defined.
module conv33_window
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_0_0,
  output logic [DATA_WIDTH-1:0] out_0_1,
  output logic [DATA_WIDTH-1:0] out_0_2,
  output logic [DATA_WIDTH-1:0] out_1_0,
  output logic [DATA_WIDTH-1:0] out_1_1,
  output logic [DATA_WIDTH-1:0] out_1_2,
  output logic [DATA_WIDTH-1:0] out_2_0,
  output logic [DATA_WIDTH-1:0] out_2_1,
  output logic [DATA_WIDTH-1:0] out_2_2,
  output logic                  frame_done
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic          col_last, row_last, win_ok, stride_ok;
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win;

  // A pixel accepted together with frame_start is coordinate (0,0).
  assign cur_col  = frame_start ? '0 : col_cnt;
  assign cur_row  = frame_start ? '0 : row_cnt;
  assign col_last = (cur_col == COL_LAST);
  assign row_last = (cur_row == ROW_LAST);

`ifdef CONV33_WINDOW_STRIDE2_EN
  assign stride_ok = ~cur_row[0] & ~cur_col[0];
`else
  assign stride_ok = 1'b1;
`endif

  assign win_ok = (cur_row >= RW'(2)) && (cur_col >= CW'(2)) && stride_ok;

  // lb1 holds row r-1, lb0 holds row r-2; lb0 takes lb1's old word on each write.
  conv33_linebuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) lb1 (
    .clk(clk), .we(in_valid), .addr(cur_col), .wdata(in_data), .rdata(lb1_rd)
  );

  conv33_linebuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) lb0 (
    .clk(clk), .we(in_valid), .addr(cur_col), .wdata(lb1_rd), .rdata(lb0_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : cur_row + RW'(1);
      end else begin
        col_cnt <= cur_col + CW'(1);
        row_cnt <= cur_row;
      end
    end else if (frame_start) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= in_valid && win_ok;
      frame_done <= in_valid && row_last && col_last;
      if (in_valid) begin
        for (int r = 0; r < KSIZE; r++)
          for (int c = 0; c < KSIZE - 1; c++)
            win[r][c] <= win[r][c+1];
        win[0][KSIZE-1] <= lb0_rd;
        win[1][KSIZE-1] <= lb1_rd;
        win[2][KSIZE-1] <= in_data;
      end
    end
  end

  assign out_0_0 = win[0][0];
  assign out_0_1 = win[0][1];
  assign out_0_2 = win[0][2];
  assign out_1_0 = win[1][0];
  assign out_1_1 = win[1][1];
  assign out_1_2 = win[1][2];
  assign out_2_0 = win[2][0];
  assign out_2_1 = win[2][1];
  assign out_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// Bench for conv33_window on a 5x5 image: scenario table plus hand sequences for reset/frame_start.
module tb_conv33_window;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
`ifdef CONV33_WINDOW_STRIDE2_EN
  localparam int WPF = 4;
`else
  localparam int WPF = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_valid, frame_done;
  logic [DW-1:0] out_0_0, out_0_1, out_0_2, out_1_0, out_1_1, out_1_2, out_2_0, out_2_1, out_2_2;

  conv33_window #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid),
    .out_0_0(out_0_0), .out_0_1(out_0_1), .out_0_2(out_0_2),
    .out_1_0(out_1_0), .out_1_1(out_1_1), .out_1_2(out_1_2),
    .out_2_0(out_2_0), .out_2_1(out_2_1), .out_2_2(out_2_2),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef logic [8:0][DW-1:0] win_t;
  typedef struct { win_t win; logic last; } exp_t;
  typedef struct { int gap; int frames; int exp_win; int exp_fd; } scn_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   mr = 0, mc = 0, mf = 0;
  int   n_win, n_fd;
  logic got_first;
  win_t first_win, last_win, exp_first, exp_last;

  function automatic logic [DW-1:0] pix(input int f, input int r, input int c);
    return DW'(f * 25 + r * W + c + 1);
  endfunction

  function automatic win_t dut_win();
    win_t w;
    w[0] = out_0_0; w[1] = out_0_1; w[2] = out_0_2;
    w[3] = out_1_0; w[4] = out_1_1; w[5] = out_1_2;
    w[6] = out_2_0; w[7] = out_2_1; w[8] = out_2_2;
    return w;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic exp_ov, exp_fd;
    exp_ov = (sb.size() > 0);
    exp_fd = exp_ov ? sb[0].last : 1'b0;
    check("valid_done", 80'({out_valid, frame_done}), 80'({exp_ov, exp_fd}));
    if (out_valid) begin
      n_win++;
      if (!got_first) begin first_win = dut_win(); got_first = 1'b1; end
    end
    if (frame_done) begin n_fd++; last_win = dut_win(); end
    if (exp_ov) begin
      e = sb.pop_front();
      if (out_valid) check("window", 80'(dut_win()), 80'(e.win));
    end
  endtask

  // Drive one cycle; accepted pixels come from the model's own raster coordinates.
  task automatic step(input logic v, input logic fs);
    exp_t e;
    logic sok;
    in_valid    = v;
    frame_start = fs;
    in_data     = DW'($urandom);
    if (fs) begin mr = 0; mc = 0; end
    if (v) begin
      in_data = pix(mf, mr, mc);
`ifdef CONV33_WINDOW_STRIDE2_EN
      sok = (mr % 2 == 0) && (mc % 2 == 0);
`else
      sok = 1'b1;
`endif
      if (mr >= 2 && mc >= 2 && sok) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            e.win[rr*3+cc] = pix(mf, mr - 2 + rr, mc - 2 + cc);
        e.last = (mr == H - 1) && (mc == W - 1);
        sb.push_back(e);
      end
      if (mc == W - 1) begin
        mc = 0;
        if (mr == H - 1) begin mr = 0; mf++; end
        else mr++;
      end else mc++;
    end
    @(posedge clk); #1;
    monitor();
  endtask

  task automatic clear_stats();
    n_win = 0; n_fd = 0; got_first = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int ew, input int ef);
    check({tag, "_windows"}, 80'(n_win), 80'(ew));
    check({tag, "_frame_done"}, 80'(n_fd), 80'(ef));
  endtask

  initial begin
    scn_t scn [3];
    int   k_first [9];
    int   k_last  [9];
    scn[0] = '{gap: 0, frames: 1, exp_win: WPF,     exp_fd: 1};
    scn[1] = '{gap: 3, frames: 1, exp_win: WPF,     exp_fd: 1};
    scn[2] = '{gap: 0, frames: 2, exp_win: 2 * WPF, exp_fd: 2};
    k_first = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    k_last  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    for (int i = 0; i < 9; i++) begin
      exp_first[i] = DW'(k_first[i]);
      exp_last[i]  = DW'(k_last[i]);
    end

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_outs", 80'({out_valid, frame_done, dut_win()}), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      clear_stats();
      mf = 0;
      for (int p = 0; p < scn[s].frames * W * H; p++) begin
        step(1'b1, 1'b0);
        for (int g = 0; g < scn[s].gap; g++) step(1'b0, 1'b0);
      end
      check_counts($sformatf("scn%0d", s), scn[s].exp_win, scn[s].exp_fd);
      if (s == 0) begin
        check("first_window", 80'(first_win), 80'(exp_first));
        check("last_window", 80'(last_win), 80'(exp_last));
      end
    end

    // Reset mid-frame after pixel 17, then a full frame.
    mf = 0;
    for (int p = 0; p < 17; p++) step(1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    #1 check("midreset_outs", 80'({out_valid, frame_done, dut_win()}), 80'(0));
    @(posedge clk); #1;
    check("midreset_hold", 80'({out_valid, frame_done, dut_win()}), 80'(0));
    rst = 1'b0;
    mr = 0; mc = 0; mf = 0;
    clear_stats();
    for (int p = 0; p < W * H; p++) step(1'b1, 1'b0);
    check_counts("after_reset", WPF, 1);
    check("after_reset_first", 80'(first_win), 80'(exp_first));

    // frame_start with in_valid at pixel 8 restarts at (0,0).
    clear_stats();
    mf = 0;
    for (int p = 0; p < 7; p++) step(1'b1, 1'b0);
    mf = 1;
    step(1'b1, 1'b1);
    for (int p = 1; p < W * H; p++) step(1'b1, 1'b0);
    check_counts("fs_with_valid", WPF, 1);

    // frame_start alone after 12 pixels, then a full frame.
    clear_stats();
    mf = 0;
    for (int p = 0; p < 12; p++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    mf = 2;
    for (int p = 0; p < W * H; p++) step(1'b1, 1'b0);
    check_counts("fs_alone", WPF, 1);

    check("scoreboard_empty", 80'(sb.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv33_window.md
Name: conv33_window

Overview:
- Upstream stage of the conv33 engine. It accepts a raster-order pixel stream, one pixel per valid cycle.
- It holds the two previous image rows in line buffers and a 3x3 shift-register window.
- For each valid 3x3 neighbourhood it presents nine pixels on out_0_0..out_2_2 with a one-cycle out_valid pulse. These connect directly to conv33 in_0_0..in_2_2 and input_valid.
- "Valid" convolution only (no padding). Stride 1 by default.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- IMG_W, 28: pixels per row. Must be >= 3.
- IMG_H, 28: rows per frame. Must be >= 3.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- frame_start  in  1  synchronous frame restart; clears the row/col counters.
- in_valid  in  1  in_data is accepted this cycle. No backpressure.
- in_data  in  DATA_WIDTH  pixel, raster order, row 0 first.
- out_valid  out  1  one-cycle pulse: the window outputs hold a new valid window.
- out_0_0..out_2_2  out  DATA_WIDTH each  window pixel; out_r_c = pixel (row-2+r, col-2+c).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, rst=1):
  - row_cnt and col_cnt go to 0.
  - All window registers go to 0, so every out_r_c = 0.
  - out_valid = 0, frame_done = 0.
  - Line-buffer contents are not cleared. They are don't-care because output is gated by row >= 2.
- Counters: col_cnt is 0..IMG_W-1 and row_cnt is 0..IMG_H-1, each $clog2-wide.
  - They advance only on accepted pixels (in_valid=1).
  - col wraps to 0 and row increments at col=IMG_W-1.
  - At (IMG_H-1, IMG_W-1) both wrap to 0; the next pixel starts a new frame automatically.
- Accepted pixel at (r,c), all at the same clock edge:
  - Read line buffers at address c: lb1 gives row r-1, lb0 gives row r-2.
  - Write lb1[c] <= in_data and lb0[c] <= old lb1[c] (read-before-write).
  - Shift the window left one column; the new right column is {lb0[c], lb1[c], in_data}.
- Output registers: out_valid <= (in_valid && r >= 2 && c >= 2), registered.
  - Latency is 1 cycle from the accepted pixel to out_valid.
  - Outputs hold their values until the next accepted pixel. With no in_valid, out_valid = 0.
- The window spans columns c-2..c. At c < 2 it holds stale or previous-row data, but out_valid is suppressed there, so no wrap-around contamination reaches conv33.
- Window count: exactly (IMG_H-2)*(IMG_W-2) out_valid pulses per frame.
- frame_done: registered, asserted the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted. It coincides with the last out_valid.
- frame_start:
  - frame_start=1 without in_valid: counters go to 0 on the next edge; the window is not cleared.
  - frame_start=1 with in_valid in the same cycle: that pixel is treated as (0,0) and counters go to (0,1).
  - Mid-frame use abandons the frame; no frame_done is issued for it.
- No gaps are required: in_valid may be held high continuously or toggled arbitrarily.

Optional Feature:
- Macro: CONV33_WINDOW_STRIDE2_EN.
- Defined: out_valid additionally requires (r-2) even and (c-2) even, i.e. stride 2. The window count per frame is floor((IMG_H-1)/2)*floor((IMG_W-1)/2). frame_done timing is unchanged.
- Undefined: stride 1 as above.

Decomposition:
- Package conv33_pkg:
  - KSIZE = 3 localparam.
  - Default DATA_WIDTH.
  - Function clog2 for counter widths, shared with conv33.
- Sub-module conv33_linebuf: an IMG_W-deep, DATA_WIDTH-wide register array.
  - Combinational read and synchronous write at the same address.
  - Instantiated twice (lb0, lb1).
- The top holds the counters, the window shift registers and the output pulse logic.

Test Plan:
1. IMG_W=5, IMG_H=5, pixel value = r*5+c+1, continuous in_valid.
   - First out_valid is 1 cycle after pixel 13 is accepted, with window 1,2,3 / 6,7,8 / 11,12,13.
   - Exactly 9 pulses; the last window is 13,14,15 / 18,19,20 / 23,24,25, coincident with frame_done.
2. Same frame, with in_valid deasserted for 3 random cycles between each pixel.
   - Identical window sequence; out_valid is never high in a cycle following in_valid=0.
3. Two back-to-back frames with no frame_start.
   - Second frame gives 9 windows with correct values, none straddling frames, and 2 frame_done pulses.
4. Assert rst mid-frame after pixel 17, then restart the frame.
   - All outputs are 0 during reset; windows after restart match scenario 1 exactly.
5. frame_start pulsed together with in_valid at pixel 8, then a full frame follows.
   - That pixel is treated as (0,0); no frame_done for the aborted frame; 9 correct windows follow.
6. CONV33_WINDOW_STRIDE2_EN defined, with scenario 1 stimulus.
   - Exactly 4 pulses, at (2,2), (2,4), (4,2), (4,4); the out_2_2 values are 13, 15, 23, 25.
